tomasulo_regstat_file: RTL and testbench

TOMASULO_REGSTAT_FILE -- requirements
Module: tomasulo_regstat_file

---
 rtl/tomasulo_pkg.sv | 6 +
 rtl/tomasulo_regstat_file_entry.sv | 43 ++++
 rtl/tomasulo_regstat_file.sv | 89 ++++++++
 tb/tb_tomasulo_regstat_file.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// tomasulo_pkg: shared reservation-station tag type and constants for the Tomasulo core.
package tomasulo_pkg;
    localparam int TAGW_DEF = 4;
    typedef logic [TAGW_DEF-1:0] tag_t;
    localparam tag_t TAG_NONE = '0;
endpackage

// File: rtl/tomasulo_regstat_file_entry.sv
// regstat_entry: one renamed register (value, busy, producer tag) with CDB capture and issue priority.
module regstat_entry
    import tomasulo_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int TAGW = TAGW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_issue,
    input  logic [TAGW-1:0] i_issue_tag,
    input  logic            i_cdb_valid,
    input  logic [TAGW-1:0] i_cdb_tag,
    input  logic [XLEN-1:0] i_cdb_data,
    input  logic            i_flush,
    output logic [XLEN-1:0] o_value,
    output logic            o_busy,
    output logic [TAGW-1:0] o_tag
);
    logic [XLEN-1:0] r_value;
    logic            r_busy;
    logic [TAGW-1:0] r_tag;
    logic            w_hit;

    assign w_hit = i_cdb_valid && r_busy && r_tag == i_cdb_tag;

    // flush beats issue beats wakeup for busy/tag; the value capture is independent of both
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
            r_busy  <= 1'b0;
            r_tag   <= '0;
        end else begin
            r_value <= w_hit ? i_cdb_data : r_value;
            r_busy  <= i_flush ? 1'b0 : i_issue ? 1'b1 : w_hit ? 1'b0 : r_busy;
            r_tag   <= i_flush ? '0 : i_issue ? i_issue_tag : w_hit ? '0 : r_tag;
        end
    end

    assign o_value = r_value;
    assign o_busy  = r_busy;
    assign o_tag   = r_tag;
endmodule

// File: rtl/tomasulo_regstat_file.sv
// tomasulo_regstat_file: register file with rename status, CDB wakeup and multi-port reads.
// Optional REGSTAT_BYPASS_EN forwards a same-cycle CDB broadcast to the read ports.
module tomasulo_regstat_file
    import tomasulo_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 4,
    parameter int TAGW  = TAGW_DEF,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        issue_valid,
    input  logic [AW-1:0]               issue_rd,
    input  logic [TAGW-1:0]             issue_tag,
    input  logic                        cdb_valid,
    input  logic [TAGW-1:0]             cdb_tag,
    input  logic [XLEN-1:0]             cdb_data,
    input  logic                        flush,
    input  logic [NREAD-1:0][AW-1:0]    raddr,
    output logic [NREAD-1:0][XLEN-1:0]  rdata,
    output logic [NREAD-1:0]            rbusy,
    output logic [NREAD-1:0][TAGW-1:0]  rtag,
    output logic [AW:0]                 busy_cnt
);
    localparam logic [TAGW-1:0] NONE = TAGW'(TAG_NONE);

    logic [XLEN-1:0] w_val [NREGS];
    logic [TAGW-1:0] w_tag [NREGS];
    logic [NREGS-1:0] w_busy;
    logic [NREAD-1:0] w_byp;
    logic            w_issue_ok;
    logic            w_cdb_ok;
    logic [AW:0]     w_cnt;
    logic [AW:0]     r_cnt;

    assign w_issue_ok = issue_valid && issue_tag != NONE && !flush;
    assign w_cdb_ok   = cdb_valid && cdb_tag != NONE;

    // x0 is hardwired: no entry, constant zero state
    assign w_val[0]  = '0;
    assign w_tag[0]  = '0;
    assign w_busy[0] = 1'b0;

    for (genvar g = 1; g < NREGS; g++) begin : g_ent
        regstat_entry #(.XLEN(XLEN), .TAGW(TAGW)) u_ent (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_issue     (w_issue_ok && issue_rd == AW'(g)),
            .i_issue_tag (issue_tag),
            .i_cdb_valid (w_cdb_ok),
            .i_cdb_tag   (cdb_tag),
            .i_cdb_data  (cdb_data),
            .i_flush     (flush),
            .o_value     (w_val[g]),
            .o_busy      (w_busy[g]),
            .o_tag       (w_tag[g])
        );
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_byp
`ifdef REGSTAT_BYPASS_EN
        assign w_byp[p] = w_cdb_ok && w_busy[raddr[p]] && w_tag[raddr[p]] == cdb_tag;
`else
        assign w_byp[p] = 1'b0;
`endif
    end

    always_comb begin
        for (int p = 0; p < NREAD; p++) begin
            rdata[p] = w_byp[p] ? cdb_data : w_val[raddr[p]];
            rbusy[p] = w_busy[raddr[p]] && !w_byp[p];
            rtag[p]  = w_byp[p] ? NONE : w_tag[raddr[p]];
        end
    end

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < NREGS; i++) w_cnt = w_cnt + (AW+1)'(w_busy[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else r_cnt <= w_cnt;
    end

    assign busy_cnt = r_cnt;
endmodule

// File: tb/tb_tomasulo_regstat_file.sv
// tb_tomasulo_regstat_file: directed scenarios plus randomized traffic against an array-based model.
module tb_tomasulo_regstat_file;
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             issue_valid = 1'b0;
    logic [4:0]       issue_rd = '0;
    logic [3:0]       issue_tag = '0;
    logic             cdb_valid = 1'b0;
    logic [3:0]       cdb_tag = '0;
    logic [31:0]      cdb_data = '0;
    logic             flush = 1'b0;
    logic [3:0][4:0]  raddr = '0;
    logic [3:0][31:0] rdata;
    logic [3:0]       rbusy;
    logic [3:0][3:0]  rtag;
    logic [5:0]       busy_cnt;

    int total = 0;
    int bad = 0;

    logic [31:0] m_val [32];
    logic        m_busy [32];
    logic [3:0]  m_tag [32];
    int          m_cnt;

    tomasulo_regstat_file dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_tag(issue_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .flush(flush), .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .rtag(rtag),
        .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_val[r] = '0;
            m_busy[r] = 1'b0;
            m_tag[r] = '0;
        end
        m_cnt = 0;
    endtask

    // expected read view of one register, including the optional same-cycle forward
    function automatic logic [36:0] exp_read(input logic [4:0] a);
        logic byp;
        if (a == 0) return '0;
        byp = 1'b0;
`ifdef REGSTAT_BYPASS_EN
        byp = cdb_valid && cdb_tag != 0 && m_busy[a] && m_tag[a] == cdb_tag;
`endif
        if (byp) return {cdb_data, 1'b0, 4'd0};
        return {m_val[a], m_busy[a], m_tag[a]};
    endfunction

    task automatic clear_inputs();
        issue_valid = 1'b0;
        cdb_valid = 1'b0;
        flush = 1'b0;
        issue_tag = '0;
        cdb_tag = '0;
    endtask

    // one rising edge, with the model taking the same step; returns at the following falling edge
    task automatic step();
        int pc;
        logic hit;
        @(posedge clk);
        pc = 0;
        for (int r = 0; r < 32; r++) pc += int'(m_busy[r]);
        for (int r = 1; r < 32; r++) begin
            hit = cdb_valid && cdb_tag != 0 && m_busy[r] && m_tag[r] == cdb_tag;
            if (hit) m_val[r] = cdb_data;
            if (flush) begin
                m_busy[r] = 1'b0;
                m_tag[r] = '0;
            end else if (issue_valid && issue_tag != 0 && issue_rd == 5'(r)) begin
                m_busy[r] = 1'b1;
                m_tag[r] = issue_tag;
            end else if (hit) begin
                m_busy[r] = 1'b0;
                m_tag[r] = '0;
            end
        end
        m_cnt = pc;
        @(negedge clk);
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        raddr = {4{5'd5}};
        #12;
        for (int p = 0; p < 4; p++) begin
            total++;
            if ({rdata[p], rbusy[p], rtag[p]} !== 37'd0) begin
                bad++;
                $display("FAIL reset_read port%0d got d=%h b=%b t=%h want 0", p, rdata[p], rbusy[p], rtag[p]);
            end
        end
        total++;
        if (busy_cnt !== 6'd0) begin
            bad++;
            $display("FAIL reset_cnt got %0d want 0", busy_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cdb_wakeup();
        raddr = {4{5'd3}};
        issue_valid = 1'b1; issue_rd = 5'd3; issue_tag = 4'd2;
        step();
        clear_inputs();
        cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_data = 32'hDEADBEEF;
        #1;
        total++;
        if (busy_cnt !== 6'd0) begin
            bad++;
            $display("FAIL wake_cnt_lag got %0d want 0", busy_cnt);
        end
        step();
        clear_inputs();
        #1;
        total++;
        if (rdata[2] !== 32'hDEADBEEF || rbusy[2] !== 1'b0 || rtag[2] !== 4'd0) begin
            bad++;
            $display("FAIL wake_read got d=%h b=%b t=%h want deadbeef 0 0", rdata[2], rbusy[2], rtag[2]);
        end
        total++;
        if (busy_cnt !== 6'd1) begin
            bad++;
            $display("FAIL wake_cnt1 got %0d want 1", busy_cnt);
        end
        step();
        total++;
        if (busy_cnt !== 6'd0) begin
            bad++;
            $display("FAIL wake_cnt0 got %0d want 0", busy_cnt);
        end
    endtask

    task automatic test_issue_wins();
        raddr = {4{5'd4}};
        issue_valid = 1'b1; issue_rd = 5'd4; issue_tag = 4'd5;
        step();
        issue_tag = 4'd7;
        cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_data = 32'h11;
        step();
        clear_inputs();
        #1;
        total++;
        if (rdata[1] !== 32'h11 || rbusy[1] !== 1'b1 || rtag[1] !== 4'd7) begin
            bad++;
            $display("FAIL issue_wins got d=%h b=%b t=%h want 11 1 7", rdata[1], rbusy[1], rtag[1]);
        end
        cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_data = 32'h22;
        step();
        clear_inputs();
    endtask

    task automatic test_bypass();
        raddr = {4{5'd6}};
        issue_valid = 1'b1; issue_rd = 5'd6; issue_tag = 4'd3;
        step();
        clear_inputs();
        cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_data = 32'h55;
        #1;
        total++;
`ifdef REGSTAT_BYPASS_EN
        if (rdata[0] !== 32'h55 || rbusy[0] !== 1'b0 || rtag[0] !== 4'd0) begin
            bad++;
            $display("FAIL bypass_same got d=%h b=%b t=%h want 55 0 0", rdata[0], rbusy[0], rtag[0]);
        end
`else
        if (rbusy[0] !== 1'b1 || rtag[0] !== 4'd3) begin
            bad++;
            $display("FAIL nobypass_same got b=%b t=%h want 1 3", rbusy[0], rtag[0]);
        end
`endif
        step();
        clear_inputs();
        #1;
        total++;
        if (rdata[3] !== 32'h55 || rbusy[3] !== 1'b0) begin
            bad++;
            $display("FAIL bypass_next got d=%h b=%b want 55 0", rdata[3], rbusy[3]);
        end
    endtask

    task automatic test_flush();
        logic [31:0] v [4];
        raddr = {5'd10, 5'd9, 5'd2, 5'd1};
        issue_valid = 1'b1;
        issue_rd = 5'd1; issue_tag = 4'd1; step();
        issue_rd = 5'd2; issue_tag = 4'd2; step();
        issue_rd = 5'd9; issue_tag = 4'd6; step();
        for (int p = 0; p < 4; p++) v[p] = m_val[raddr[p]];
        issue_rd = 5'd10; issue_tag = 4'd4; flush = 1'b1;
        step();
        clear_inputs();
        #1;
        for (int p = 0; p < 4; p++) begin
            total++;
            if (rbusy[p] !== 1'b0 || rtag[p] !== 4'd0 || rdata[p] !== v[p]) begin
                bad++;
                $display("FAIL flush_read port%0d got d=%h b=%b t=%h want %h 0 0", p, rdata[p], rbusy[p], rtag[p], v[p]);
            end
        end
        step();
        total++;
        if (busy_cnt !== 6'd0) begin
            bad++;
            $display("FAIL flush_cnt got %0d want 0", busy_cnt);
        end
    endtask

    task automatic test_x0_and_async_reset();
        raddr = {5'd3, 5'd0, 5'd0, 5'd0};
        issue_valid = 1'b1; issue_rd = 5'd0; issue_tag = 4'd1;
        step();
        clear_inputs();
        cdb_valid = 1'b1; cdb_tag = 4'd1; cdb_data = 32'hFF;
        step();
        clear_inputs();
        #1;
        total++;
        if ({rdata[0], rbusy[0], rtag[0]} !== 37'd0 || busy_cnt !== 6'd0) begin
            bad++;
            $display("FAIL x0_read got d=%h b=%b t=%h cnt=%0d want 0", rdata[0], rbusy[0], rtag[0], busy_cnt);
        end
        issue_valid = 1'b1; issue_rd = 5'd5; issue_tag = 4'd8;
        step();
        step();
        clear_inputs();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (rdata[3] !== 32'd0 || busy_cnt !== 6'd0) begin
            bad++;
            $display("FAIL async_reset got x3=%h cnt=%0d want 0 0", rdata[3], busy_cnt);
        end
        raddr[0] = 5'd5;
        #1;
        total++;
        if (rbusy[0] !== 1'b0 || rtag[0] !== 4'd0) begin
            bad++;
            $display("FAIL async_reset_x5 got b=%b t=%h want 0 0", rbusy[0], rtag[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [36:0] e;
        int nbad;
        nbad = 0;
        for (int c = 0; c < 400; c++) begin
            issue_valid = ($urandom_range(0, 2) != 0);
            issue_rd = 5'($urandom_range(0, 31));
            issue_tag = 4'($urandom_range(0, 15));
            cdb_valid = ($urandom_range(0, 1) != 0);
            cdb_tag = 4'($urandom_range(0, 15));
            cdb_data = $urandom;
            flush = ($urandom_range(0, 29) == 0);
            for (int p = 0; p < 4; p++) raddr[p] = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) != 0) begin
                raddr[1] = issue_rd;
                raddr[2] = raddr[0];
            end
            #1;
            for (int p = 0; p < 4; p++) begin
                e = exp_read(raddr[p]);
                total++;
                if ({rdata[p], rbusy[p], rtag[p]} !== e) begin
                    bad++;
                    nbad++;
                    if (nbad < 10)
                        $display("FAIL rand_read c=%0d port%0d a=%0d got %h_%b_%h want %h_%b_%h", c, p, raddr[p],
                                 rdata[p], rbusy[p], rtag[p], e[36:5], e[4], e[3:0]);
                end
            end
            total++;
            if (busy_cnt !== 6'(m_cnt)) begin
                bad++;
                nbad++;
                if (nbad < 10) $display("FAIL rand_cnt c=%0d got %0d want %0d", c, busy_cnt, m_cnt);
            end
            step();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_cdb_wakeup();
        test_issue_wins();
        test_bypass();
        test_flush();
        test_x0_and_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
